line_burst_adapter: RTL and testbench

Converts the L1 cache's single-transfer 256-bit line interface into four-beat, 64-bit bursts toward physical memory, and reassembles four returned beats into one line. It sits directly below the L1 cache. Its line side connects to the cache's `pmem_*` signals, and its burst side connects to main memory or the arbiter. It holds one transaction at a time: a writeback or a fill.

---
 rtl/line_burst_pkg.sv | 16 +
 rtl/line_burst_adapter.sv | 95 +++++++++
 tb/tb_line_burst_adapter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_pkg.sv
// Shared types and constants for the line-to-burst adapter.
package line_burst_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } lba_state_t;

endpackage

// File: rtl/line_burst_adapter.sv
// Splits a cache line writeback into four memory beats and reassembles four
// returned beats into a fill line; one transaction in flight at a time.
module line_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);
  import line_burst_pkg::*;

  localparam int               BEATS     = LINE_W / BURST_W;
  localparam int               CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  lba_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic              unused_offset;

  assign unused_offset = ^line_address[OFFSET_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        // Write has priority if the cache ever raises both requests.
        if (line_write) begin
          buf_d   = line_wdata;
          addr_d  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (line_read) begin
          addr_d  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (burst_resp) begin
          buf_d[BURST_W*cnt_q +: BURST_W] = burst_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (burst_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All memory-side outputs come straight from registered state.
  assign burst_read    = (state_q == RD_BURST);
  assign burst_write   = (state_q == WR_BURST);
  assign line_resp     = (state_q == DONE);
  assign burst_address = addr_q;
  assign line_rdata    = buf_q;
  assign burst_wdata   = burst_write ? buf_q[BURST_W*cnt_q +: BURST_W] : '0;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter with a transaction-level reference model.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  int nchecks = 0;
  int nerrors = 0;
  int resp_cnt = 0;

  line_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: kind 0 = nothing pending, 1 = fill, 2 = writeback.
  int           m_kind = 0;
  int           m_beats = 0;
  bit           m_done = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_line = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind = 0; m_beats = 0; m_done = 0; m_addr = '0; m_line = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_kind == 0) begin
      if (line_write || line_read) begin
        m_kind  = line_write ? 2 : 1;
        m_addr  = line_address & 32'hFFFF_FFE0;
        m_beats = 0;
        if (line_write) m_line = line_wdata;
      end
    end else if (burst_resp) begin
      if (m_kind == 1) m_line[64*m_beats +: 64] = burst_rdata;
      m_beats++;
      if (m_beats == 4) begin
        m_kind = 0;
        m_done = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("burst_read", burst_read, m_kind == 1);
    chk("burst_write", burst_write, m_kind == 2);
    chk("line_resp", line_resp, m_done);
    chk("burst_address", burst_address, m_addr);
    chk("burst_wdata", burst_wdata, (m_kind == 2) ? m_line[64*m_beats +: 64] : 64'h0);
    chk("line_rdata", line_rdata, m_line);
    if (line_resp === 1'b1) resp_cnt++;
  end

  // Drives one request from the IDLE cycle, answers as memory with the given
  // accept pattern (bit k = burst_resp in the k-th burst cycle), measures latency.
  task automatic txn(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [255:0] wd, input logic [255:0] rline, input logic [15:0] pat,
                     input int exp_lat, output logic [255:0] wcap);
    int n = 0;
    int k = 0;
    int beat = 0;
    bit got = 0;
    bit saw_rd = 0;
    wcap = '0;
    line_read = rd; line_write = wr; line_address = a; line_wdata = wd;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({nm, "_req_visible"}, burst_read | burst_write, 1'b1);
      if (burst_read) saw_rd = 1;
      burst_resp = 1'b0;
      if (line_resp) begin
        got = 1;
        line_read = 1'b0;
        line_write = 1'b0;
      end else if (burst_read | burst_write) begin
        burst_rdata = rline[64*(beat % 4) +: 64];
        burst_resp  = (k < 16) ? pat[k] : 1'b1;
        k++;
        if (burst_resp && beat < 4) begin
          if (burst_write) wcap[64*beat +: 64] = burst_wdata;
          beat++;
        end
      end
    end
    line_read = 1'b0;
    line_write = 1'b0;
    chk({nm, "_latency"}, n, exp_lat);
    if (rd && wr) chk({nm, "_no_read"}, saw_rd, 1'b0);
    @(negedge clk);
  endtask

  logic [255:0] cap, fill1, wline, w2, r2, w3;
  int           c0;

  initial begin
    fill1 = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, 64'h0};
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    w2    = {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
             64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001};
    r2    = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
    w3    = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
             64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {line_resp, burst_read, burst_write, burst_address, burst_wdata}, '0);
    chk("reset_rdata", line_rdata, '0);
    rst = 1'b1;
    @(negedge clk);

    txn("fill0", 1'b1, 1'b0, 32'h8000_0044, '0, fill1, 16'hFFFF, 5, cap);
    chk("fill0_line", line_rdata,
        {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0});
    chk("fill0_addr", burst_address, 32'h8000_0040);

    repeat (4) begin
      burst_resp = 1'b1;
      burst_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    chk("spurious_line", line_rdata, fill1);
    chk("spurious_idle", {burst_read, burst_write, line_resp}, 3'b000);

    txn("wb_stall", 1'b0, 1'b1, 32'h0000_1234, wline, '0, 16'h5555, 8, cap);
    chk("wb_beats", cap, wline);
    chk("wb_beat0", cap[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
    chk("wb_addr", burst_address, 32'h0000_1220);

    c0 = resp_cnt;
    txn("chain_wr", 1'b0, 1'b1, 32'h0000_2000, w2, '0, 16'hFFFF, 5, cap);
    chk("chain_wr_beats", cap, w2);
    txn("chain_rd", 1'b1, 1'b0, 32'h0000_301F, '0, r2, 16'hFFF3, 7, cap);
    chk("chain_resp_pulses", resp_cnt - c0, 2);
    chk("chain_rd_line", line_rdata, r2);
    chk("chain_rd_addr", burst_address, 32'h0000_3000);

    txn("both", 1'b1, 1'b1, 32'h4000_0010, w3, r2, 16'hFFFF, 5, cap);
    chk("both_beats", cap, w3);
    chk("both_line", line_rdata, w3);

    line_read = 1'b1;
    line_address = 32'h0000_5000;
    @(negedge clk);
    burst_resp = 1'b1;
    burst_rdata = 64'h1;
    @(negedge clk);
    burst_rdata = 64'h2;
    @(negedge clk);
    burst_resp = 1'b0;
    line_read = 1'b0;
    chk("pre_rst_busy", burst_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ctrl", {burst_read, burst_write, line_resp}, 3'b000);
    chk("rst_async_addr", burst_address, 32'h0);
    chk("rst_async_wdata", burst_wdata, 64'h0);
    chk("rst_async_rdata", line_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c0 = resp_cnt;
    repeat (8) @(negedge clk);
    chk("rst_no_resp", resp_cnt - c0, 0);
    chk("rst_idle", {burst_read, burst_write}, 2'b00);

    txn("fill_after_rst", 1'b1, 1'b0, 32'h0000_6018, '0, r2, 16'hFFFF, 5, cap);
    chk("fill_after_rst_line", line_rdata, r2);
    chk("fill_after_rst_addr", burst_address, 32'h0000_6000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
